demux_stream_1n: RTL and testbench

//  Registered 1:NUM_CH stream demultiplexer. It generalises the combinational 1:4 demux to

---
 rtl/demux_stream_1n.sv | 88 ++++++++
 tb/tb_demux_stream_1n.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_1n.sv
// Registered 1:NUM_CH stream demultiplexer with per-channel one-entry holding
// registers, unicast/broadcast steering and a saturating drop counter for
// beats addressed to a channel that does not exist.
module demux_stream_1n #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam logic [SEL_W:0]   NumChW = (SEL_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [NUM_CH-1:0]        valid_q, valid_d;
  logic [NUM_CH*DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]         dropCnt_q, dropCnt_d;
  logic [NUM_CH-1:0]        canLoad;
  logic [NUM_CH-1:0]        loadCh;
  logic                     selInRange;
  logic                     selReady;
  logic                     accept;

  // Work out which channels can take a beat and derive the producer handshake.
  always_comb begin
    canLoad    = ~valid_q | out_ready;
    selInRange = ({1'b0, in_sel} < NumChW);
    selReady   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (in_sel == SEL_W'(k)) selReady = canLoad[k];
    end
    if (rst) begin
      in_ready = 1'b1;
    end else if (in_bcast) begin
      in_ready = &canLoad;
    end else if (selInRange) begin
      in_ready = selReady;
    end else begin
      in_ready = 1'b1;
    end
    accept = in_valid & in_ready & ~rst;
  end

  // Next state of every holding register and of the drop counter.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    dropCnt_d = dropCnt_q;
    loadCh    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      loadCh[k]  = accept & (in_bcast | (selInRange & (in_sel == SEL_W'(k))));
      valid_d[k] = loadCh[k] | (valid_q[k] & ~out_ready[k]);
      if (loadCh[k]) data_d[k*DATA_W +: DATA_W] = in_data;
    end
    if (accept && !in_bcast && !selInRange && (dropCnt_q != CntMax)) begin
      dropCnt_d = dropCnt_q + CNT_W'(1);
    end
  end

  // State registers; synchronous reset discards any held beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      data_q    <= '0;
      dropCnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign drop_cnt  = dropCnt_q;

endmodule

// File: tb/tb_demux_stream_1n.sv
// Scoreboard testbench for demux_stream_1n: the driver predicts each accepted
// beat into per-channel expectation queues and a separate monitor pops and
// compares whenever a channel presents its output.
module tb_demux_stream_1n;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 3;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                     clk;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_bcast;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [CNT_W-1:0]         drop_cnt;

  int checks   = 0;
  int failures = 0;
  logic checkEn = 1'b0;

  logic [DATA_W-1:0] expQ [NUM_CH][$];
  logic [DATA_W-1:0] lastData [NUM_CH];
  int dropModel = 0;

  demux_stream_1n #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Whether the block should accept a beat, from the queue occupancy view.
  function automatic logic modelReady(input logic r, input logic b,
                                      input logic [SEL_W-1:0] s,
                                      input logic [NUM_CH-1:0] rdy);
    logic all;
    if (r) return 1'b1;
    if (b) begin
      all = 1'b1;
      for (int k = 0; k < NUM_CH; k++)
        if (!(expQ[k].size() == 0 || rdy[k])) all = 1'b0;
      return all;
    end
    if (int'(s) < NUM_CH) return (expQ[s].size() == 0) || rdy[s];
    return 1'b1;
  endfunction

  // Drive one cycle of inputs and predict what the next edge does.
  task automatic applyStimulus(input logic r, input logic v,
                               input logic [DATA_W-1:0] d,
                               input logic [SEL_W-1:0] s, input logic b,
                               input logic [NUM_CH-1:0] rdy,
                               output logic accepted);
    logic expR;
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_data = d; in_sel = s; in_bcast = b;
    out_ready = rdy;
    @(negedge clk);
    #1;
    expR = modelReady(r, b, s, rdy);
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, expR});
    accepted = 1'b0;
    if (r) begin
      for (int k = 0; k < NUM_CH; k++) begin
        expQ[k].delete();
        lastData[k] = '0;
      end
      dropModel = 0;
    end else if (v && expR) begin
      accepted = 1'b1;
      if (b) begin
        for (int k = 0; k < NUM_CH; k++) begin
          expQ[k].push_back(d);
          lastData[k] = d;
        end
      end else if (int'(s) < NUM_CH) begin
        expQ[s].push_back(d);
        lastData[s] = d;
      end else if (dropModel < CNT_MAX) begin
        dropModel++;
      end
    end
  endtask

  // Monitor: compare every channel against the scoreboard and retire beats
  // that the consumer accepts.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int k = 0; k < NUM_CH; k++) begin
        logic vExp;
        logic [DATA_W-1:0] dExp;
        vExp = (expQ[k].size() != 0);
        dExp = vExp ? expQ[k][0] : lastData[k];
        checkOutput($sformatf("out_valid[%0d]", k), {31'b0, out_valid[k]}, {31'b0, vExp});
        checkOutput($sformatf("out_data[%0d]", k), {24'b0, out_data[k*DATA_W +: DATA_W]},
                    {24'b0, dExp});
        if (out_valid[k] && out_ready[k] && expQ[k].size() != 0) void'(expQ[k].pop_front());
      end
      checkOutput("drop_cnt", {30'b0, drop_cnt}, dropModel);
    end
  end

  logic acc;
  logic curV, curB;
  logic [DATA_W-1:0] curD;
  logic [SEL_W-1:0] curS;

  // Directed scenarios followed by a constrained random stream.
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0;
    out_ready = '0;

    applyStimulus(1'b1, 1'($urandom), 8'($urandom), 2'($urandom), 1'($urandom),
                  3'($urandom), acc);
    checkEn = 1'b1;
    applyStimulus(1'b1, 1'($urandom), 8'($urandom), 2'($urandom), 1'($urandom),
                  3'($urandom), acc);
    applyStimulus(1'b0, 1'b0, 8'($urandom), 2'($urandom), 1'($urandom), 3'b111, acc);
    checkOutput("reset out_valid", {29'b0, out_valid}, 32'h0);
    checkOutput("reset out_data", {8'b0, out_data}, 32'h0);
    checkOutput("reset drop_cnt", {30'b0, drop_cnt}, 32'h0);

    $display("[TB] unicast streaming");
    applyStimulus(1'b0, 1'b1, 8'h11, 2'd2, 1'b0, 3'b111, acc);
    applyStimulus(1'b0, 1'b1, 8'h22, 2'd2, 1'b0, 3'b111, acc);
    checkOutput("stream first", {8'b0, out_data[23:16], 5'b0, out_valid}, {8'b0, 8'h11, 5'b0, 3'b100});
    applyStimulus(1'b0, 1'b1, 8'h33, 2'd2, 1'b0, 3'b111, acc);
    applyStimulus(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'b111, acc);
    checkOutput("stream last", {24'b0, out_data[23:16]}, 32'h33);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 1'b1, 8'hA5, 2'd1, 1'b0, 3'b101, acc);
    applyStimulus(1'b0, 1'b1, 8'h5A, 2'd1, 1'b0, 3'b101, acc);
    checkOutput("stall reject", {31'b0, acc}, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h77, 2'd0, 1'b0, 3'b101, acc);
    checkOutput("other channel accept", {31'b0, acc}, 32'h1);
    applyStimulus(1'b0, 1'b1, 8'h5A, 2'd1, 1'b0, 3'b111, acc);
    applyStimulus(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'b000, acc);
    checkOutput("released beat", {24'b0, out_data[15:8]}, 32'h5A);

    $display("[TB] broadcast");
    applyStimulus(1'b0, 1'b1, 8'h99, 2'd2, 1'b0, 3'b111, acc);
    applyStimulus(1'b0, 1'b1, 8'hC3, 2'd0, 1'b1, 3'b011, acc);
    checkOutput("bcast blocked", {31'b0, acc}, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'hC3, 2'd0, 1'b1, 3'b111, acc);
    applyStimulus(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'b000, acc);
    checkOutput("bcast all", {5'b0, out_valid, out_data}, {5'b0, 3'b111, 24'hC3C3C3});

    $display("[TB] out-of-range drop");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b1, 8'($urandom), 2'd3, 1'b0, 3'b111, acc);
    applyStimulus(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'b111, acc);
    checkOutput("drop saturate", {30'b0, drop_cnt}, 32'h3);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 1'b1, 8'h41, 2'd0, 1'b0, 3'b000, acc);
    applyStimulus(1'b0, 1'b1, 8'h42, 2'd1, 1'b0, 3'b000, acc);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b000, acc);
    applyStimulus(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'b000, acc);
    checkOutput("midreset valid", {29'b0, out_valid}, 32'h0);
    checkOutput("midreset drop", {30'b0, drop_cnt}, 32'h0);

    $display("[TB] random stream");
    curV = 1'b0; curD = '0; curS = '0; curB = 1'b0; acc = 1'b1;
    for (int i = 0; i < 600; i++) begin
      logic r;
      if (!(curV && !acc)) begin
        curV = ($urandom_range(0, 3) != 0);
        curD = 8'($urandom);
        curS = 2'($urandom);
        curB = ($urandom_range(0, 7) == 0);
      end
      r = ($urandom_range(0, 59) == 0);
      applyStimulus(r, curV, curD, curS, curB, 3'($urandom), acc);
      if (r) acc = 1'b1;
    end
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'b111, acc);
    checkOutput("final drained", {29'b0, out_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
